// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller state encoding, bit-cell quarter-phases
// and address width, used by both the master controller and the slave.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    STOP,
    DONE
  } stateT;

  typedef enum logic [1:0] {
    PH0,
    PH1,
    PH2,
    PH3
  } phaseT;

  // Every state between accept and the completion pulse holds the bus.
  function automatic logic isBusyState(input stateT s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// Host handshake plus I2C bus lines of the master controller; the master
// modport is the controller, the slave modport is the host/bus side.
interface i2c_master_ctrl_if;
  import i2c_pkg::*;

  logic                  iStart;
  logic                  iRW;
  logic [I2C_ADDR_W-1:0] iAddr;
  logic [7:0]            iData;
  logic                  iSDA;
  logic                  SCL;
  logic                  oSDA;
  logic [7:0]            oData;
  logic                  oBusy;
  logic                  oDone;
  logic                  oAckErr;

  modport master (
    input  iStart, iRW, iAddr, iData, iSDA,
    output SCL, oSDA, oData, oBusy, oDone, oAckErr
  );

  modport slave (
    output iStart, iRW, iAddr, iData, iSDA,
    input  SCL, oSDA, oData, oBusy, oDone, oAckErr
  );

endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-phase divider: CLK_DIV cycles per phase, four phases per bit cell.
// Parked at phase 0 / count 0 whenever the controller is idle.
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic  CLK,
  input  logic  Reset,
  input  logic  busy,
  output phaseT phase,
  output logic  phaseEnd
);

  localparam int               CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign phaseEnd = busy && (count == LAST);

  // NOTE: non-blocking (<=) so every flop samples pre-edge values no matter
  // how the statements are ordered.
  always_ff @(posedge CLK) begin
    if (Reset || !busy) begin
      count <= '0;
      phase <= PH0;
    end else if (phaseEnd) begin
      count <= '0;
      phase <= phaseT'(phase + 2'd1);
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C initiator for one-byte write/read transfers to a 7-bit
// slave address, with a start/busy/done host handshake.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic                CLK,
  input logic                Reset,
  i2c_master_ctrl_if.master  bus
);

  stateT                 state, stateD;
  logic [2:0]            bitCnt, bitCntD;
  logic [7:0]            shiftQ, shiftD;
  logic                  rwQ, rwD;
  logic [I2C_ADDR_W-1:0] addrQ, addrD;
  logic [7:0]            dataQ, dataD;
  logic                  sclQ, sclD;
  logic                  sdaQ, sdaD;
  logic [7:0]            dataOutQ, dataOutD;
  logic                  busyQ, busyD;
  logic                  doneQ, doneD;
  logic                  ackErrQ, ackErrD;

  phaseT phase, phaseD;
  logic  phaseEnd;
  logic  cellEnd;
  logic  sampleNow;
  logic  highHalf;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) tickGen (
    .CLK      (CLK),
    .Reset    (Reset),
    .busy     (busyQ),
    .phase    (phase),
    .phaseEnd (phaseEnd)
  );

  assign cellEnd   = phaseEnd && (phase == PH3);
  assign sampleNow = phaseEnd && (phase == PH2);

  // Outputs are registered, so they are decoded from the state and phase
  // that will be current after this edge rather than the present ones.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    stateD   = state;
    bitCntD  = bitCnt;
    shiftD   = shiftQ;
    rwD      = rwQ;
    addrD    = addrQ;
    dataD    = dataQ;
    dataOutD = dataOutQ;
    ackErrD  = ackErrQ;
    phaseD   = phaseEnd ? phaseT'(phase + 2'd1) : phase;
    sclD     = 1'b1;
    sdaD     = 1'b1;
    highHalf = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.iStart) begin
          stateD  = START;
          rwD     = bus.iRW;
          addrD   = bus.iAddr;
          dataD   = bus.iData;
          shiftD  = {bus.iAddr, bus.iRW};
          bitCntD = '0;
          ackErrD = 1'b0;
        end
      end
      START: begin
        if (cellEnd) stateD = ADDR;
      end
      ADDR, WRITE: begin
        if (cellEnd) begin
          shiftD  = {shiftQ[6:0], 1'b0};
          bitCntD = bitCnt + 3'd1;
          if (bitCnt == 3'd7) stateD = (state == ADDR) ? ADDR_ACK : WRITE_ACK;
        end
      end
      ADDR_ACK: begin
        if (sampleNow && bus.iSDA) ackErrD = 1'b1;
        // ackErrQ already holds this cell's sample by the time the cell ends.
        if (cellEnd) begin
          if (ackErrQ) begin
            stateD = STOP;
          end else if (rwQ) begin
            stateD = READ;
          end else begin
            stateD = WRITE;
            shiftD = dataQ;
          end
        end
      end
      WRITE_ACK: begin
        if (sampleNow && bus.iSDA) ackErrD = 1'b1;
        if (cellEnd) stateD = STOP;
      end
      READ: begin
        if (sampleNow) shiftD = {shiftQ[6:0], bus.iSDA};
        if (cellEnd) begin
          bitCntD = bitCnt + 3'd1;
          if (bitCnt == 3'd7) stateD = READ_ACK;
        end
      end
      READ_ACK: begin
        if (cellEnd) stateD = STOP;
      end
      STOP: begin
        if (cellEnd) begin
          stateD = DONE;
          if (rwQ && !ackErrQ) dataOutD = shiftQ;
        end
      end
      DONE: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase

    highHalf = (phaseD == PH2) || (phaseD == PH3);

    unique case (stateD)
      START: begin
        sdaD = !highHalf;
      end
      ADDR, WRITE: begin
        sclD = highHalf;
        sdaD = shiftD[7];
      end
      ADDR_ACK, WRITE_ACK, READ, READ_ACK: begin
        sclD = highHalf;
      end
      STOP: begin
        sclD = (phaseD != PH0);
        sdaD = highHalf;
      end
      default: begin
        sclD = 1'b1;
        sdaD = 1'b1;
      end
    endcase
  end

  assign busyD = isBusyState(stateD);
  assign doneD = (stateD == DONE);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      bitCnt   <= '0;
      shiftQ   <= '0;
      rwQ      <= 1'b0;
      addrQ    <= '0;
      dataQ    <= '0;
      sclQ     <= 1'b1;
      sdaQ     <= 1'b1;
      dataOutQ <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      ackErrQ  <= 1'b0;
    end else begin
      state    <= stateD;
      bitCnt   <= bitCntD;
      shiftQ   <= shiftD;
      rwQ      <= rwD;
      addrQ    <= addrD;
      dataQ    <= dataD;
      sclQ     <= sclD;
      sdaQ     <= sdaD;
      dataOutQ <= dataOutD;
      busyQ    <= busyD;
      doneQ    <= doneD;
      ackErrQ  <= ackErrD;
    end
  end

  assign bus.SCL     = sclQ;
  assign bus.oSDA    = sdaQ;
  assign bus.oData   = dataOutQ;
  assign bus.oBusy   = busyQ;
  assign bus.oDone   = doneQ;
  assign bus.oAckErr = ackErrQ;

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Single-master I2C initiator that generates SCL and drives SDA for one-byte write or read transactions to a 7-bit-addressed slave. It is the counterpart of the team's I2C slave module (`I2C_Module2`): its SCL/oSDA outputs feed the slave's SCL/iSDA inputs, and the slave's oSDA returns on this block's iSDA. A host-side start/busy/done handshake lets a system controller, or the bench in place of the `probador`, launch transfers.

## Interface
- CLK_DIV, 4: CLK cycles per SCL quarter-phase; legal range ≥2. SCL period = 4·CLK_DIV CLK cycles.
- CLK  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- iStart  in  1  request a transaction; sampled only in IDLE.
- iRW  in  1  0 = write, 1 = read; latched on accept.
- iAddr  in  7  slave address; latched on accept.
- iData  in  8  write byte; latched on accept.
- iSDA  in  1  SDA as seen on the bus (slave ACK and read data).
- SCL  out  1  I2C clock.
- oSDA  out  1  master SDA drive; 1 = release/high, 0 = pull low.
- oData  out  8  last byte read; updated only on a completed read.
- oBusy  out  1  transaction in progress.
- oDone  out  1  one-cycle completion pulse.
- oAckErr  out  1  NACK seen in the last transaction; held until next accept.

## Operation
- Reset (any cycle, including mid-transaction): next edge SCL=1, oSDA=1, oBusy=0, oDone=0, oAckErr=0, oData=8'h00, state IDLE. No STOP is generated.
- Accept: in IDLE, iStart=1 latches iRW/iAddr/iData, clears oAckErr, and sets oBusy=1 on the next edge. iStart is ignored while oBusy=1.
- Bit cell: 4 quarter-phases of CLK_DIV cycles each.
  - Data cells: phases 0–1 SCL=0, phases 2–3 SCL=1.
  - oSDA changes only at the start of phase 0.
  - iSDA is sampled on the last cycle of phase 2.
- States and cell sequence:
  - START: SDA=1 in phases 0–1, SDA=0 in phases 2–3; SCL=1 throughout.
  - ADDR: 8 cells, {iAddr, iRW}, MSB first.
  - ADDR_ACK: oSDA=1; sampled iSDA=1 means NACK → set oAckErr, go to STOP.
  - Write path: WRITE (8 cells, iData MSB first) → WRITE_ACK (oSDA=1; NACK sets oAckErr) → STOP.
  - Read path: READ (8 cells, oSDA=1, shift in sampled iSDA MSB first) → READ_ACK (master NACK, oSDA=1) → STOP.
  - STOP: phase 0 SCL=0, SDA=0; phase 1 SCL=1, SDA=0; phases 2–3 SCL=1, SDA=1.
  - DONE: one cycle with oDone=1 and oBusy=0; oData loaded here if read and no address NACK. Return to IDLE.
- No clock stretching, arbitration, repeated start or multi-byte bursts.

## Timing
- Full transaction: 20 cells = 80·CLK_DIV cycles from the first oBusy=1 cycle to the last STOP cycle; oDone appears on the following cycle.
- Address NACK: 11 cells = 44·CLK_DIV cycles, then oDone.
- SCL is held high (1) in IDLE.
- iStart asserted during the DONE cycle is ignored; the earliest re-accept is the first IDLE cycle, giving a minimum gap of 1 cycle between oDone and the next oBusy.
- A write-data NACK still completes with STOP; oDone fires and oAckErr=1.
- oData is unchanged on writes and on aborted reads.

## Structure
- Shared package i2c_pkg holds:
  - state encoding (IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP, DONE);
  - phase constants PH0–PH3;
  - I2C_ADDR_W=7.
  The slave module reuses the same package.
- Sub-module i2c_tick_gen: quarter-phase divider with CLK_DIV parameter. It outputs a 2-bit phase and a one-cycle phase_end strobe, and is held at phase 0/count 0 whenever not busy or in Reset.
- Top level holds the FSM, a bit counter (0–7), an 8-bit shift register and the output registers. All outputs are registered.

## Test plan
All scenarios run at CLK_DIV=2 (bit cell = 8 cycles).
1. Write, addr 7'h50, data 8'hA5, slave ACKs → SDA bits 1010000_0, ACK, 10100101, ACK, STOP; oBusy for 160 cycles, then oDone pulse; oAckErr=0.
2. Address NACK (iSDA held 1), addr 7'h22 → STOP after the 9th cell; oBusy for 88 cycles; oDone=1, oAckErr=1; no data cells.
3. Read, addr 7'h28, slave returns 8'h3C → oSDA=1 during the ack cell (master NACK); oData=8'h3C on the oDone cycle; oAckErr=0.
4. Write with data NACK → full 160-cycle transaction, oAckErr=1, oData unchanged.
5. Reset asserted in cell 5 → next cycle SCL=1, oSDA=1, oBusy=0, oDone never fires; a fresh iStart afterwards completes normally.
6. iStart pulsed mid-transaction and during the DONE cycle → both ignored; iStart on the first IDLE cycle is accepted and inputs are latched from that cycle.
